gcd_unit: RTL

Parametrised multi-cycle GCD engine for the datapath exercises. It supersedes the fixed 16-bit subtractive GCD block and adds width generalisation, a selectable binary (Stein) algorithm, a valid/ready handshake on both sides, zero-operand flags and a cycle counter. Operand pairs are accepted one at a time, and each result is held until it is consumed.

---
 rtl/gcd_pkg.sv | 14 +
 rtl/gcd_step.sv | 55 +++++
 rtl/gcd_unit.sv | 135 +++++++++++++
 3 files changed

// File: rtl/gcd_pkg.sv
// Shared types and constants for the GCD engine.
package gcd_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        REDUCE = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam int ALGO_SUB = 0;
    localparam int ALGO_BIN = 1;

endpackage

// File: rtl/gcd_step.sv
// Combinational next-value logic for one GCD iteration (subtractive or Stein).
module gcd_step
    import gcd_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int ALGO  = ALGO_BIN,
    parameter int KW    = $clog2(WIDTH) + 1
) (
    input  logic             is_shift,
    input  logic             is_reduce,
    input  logic [WIDTH-1:0] ra,
    input  logic [WIDTH-1:0] rb,
    input  logic [KW-1:0]    k,
    output logic [WIDTH-1:0] ra_nx,
    output logic [WIDTH-1:0] rb_nx,
    output logic [KW-1:0]    k_nx,
    output logic [WIDTH-1:0] res,
    output logic             eq,
    output logic             both_even
);

    logic             gt;
    logic [WIDTH-1:0] diff_ab;
    logic [WIDTH-1:0] diff_ba;

    assign eq        = (ra == rb);
    assign gt        = (ra > rb);
    assign both_even = ~ra[0] & ~rb[0];
    assign diff_ab   = ra - rb;
    assign diff_ba   = rb - ra;
    assign res       = ra << k;

    always_comb begin
        ra_nx = ra;
        rb_nx = rb;
        k_nx  = k;
        if (is_shift && both_even) begin
            ra_nx = ra >> 1;
            rb_nx = rb >> 1;
            k_nx  = k + KW'(1);
        end else if (is_reduce && !eq) begin
            if (ALGO == ALGO_SUB) begin
                if (gt) ra_nx = diff_ab;
                else    rb_nx = diff_ba;
            end else begin
                // Difference of two odd values is even, so it is halved in the same step.
                if (!ra[0])      ra_nx = ra >> 1;
                else if (!rb[0]) rb_nx = rb >> 1;
                else if (gt)     ra_nx = diff_ab >> 1;
                else             rb_nx = diff_ba >> 1;
            end
        end
    end

endmodule

// File: rtl/gcd_unit.sv
// Multi-cycle GCD engine with valid/ready handshake, zero-operand flag and cycle counter.
module gcd_unit
    import gcd_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int ALGO  = ALGO_BIN,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] gcd,
    output logic             zero_err,
    output logic [CNT_W-1:0] cyc_cnt
);

    localparam int KW = $clog2(WIDTH) + 1;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] ra_q, ra_d, rb_q, rb_d;
    logic [KW-1:0]    k_q, k_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
    logic [WIDTH-1:0] gcd_q, gcd_d;
    logic             zero_q, zero_d;
    logic [CNT_W-1:0] cyc_q, cyc_d;

    logic [WIDTH-1:0] ra_nx, rb_nx, res;
    logic [KW-1:0]    k_nx;
    logic             eq, both_even;

    gcd_step #(
        .WIDTH (WIDTH),
        .ALGO  (ALGO),
        .KW    (KW)
    ) u_step (
        .is_shift  (state_q == SHIFT),
        .is_reduce (state_q == REDUCE),
        .ra        (ra_q),
        .rb        (rb_q),
        .k         (k_q),
        .ra_nx     (ra_nx),
        .rb_nx     (rb_nx),
        .k_nx      (k_nx),
        .res       (res),
        .eq        (eq),
        .both_even (both_even)
    );

    assign cnt_inc   = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);
    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign gcd       = gcd_q;
    assign zero_err  = zero_q;
    assign cyc_cnt   = cyc_q;

    always_comb begin
        state_d = state_q;
        ra_d    = ra_q;
        rb_d    = rb_q;
        k_d     = k_q;
        cnt_d   = cnt_q;
        gcd_d   = gcd_q;
        zero_d  = zero_q;
        cyc_d   = cyc_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    ra_d  = a;
                    rb_d  = b;
                    k_d   = '0;
                    cnt_d = '0;
                    if (a == '0 || b == '0) begin
                        state_d = DONE;
                        gcd_d   = a | b;
                        zero_d  = (a == '0) && (b == '0);
                        cyc_d   = '0;
                    end else begin
                        state_d = (ALGO == ALGO_BIN) ? SHIFT : REDUCE;
                    end
                end
            end
            SHIFT: begin
                cnt_d = cnt_inc;
                ra_d  = ra_nx;
                rb_d  = rb_nx;
                k_d   = k_nx;
                if (!both_even) state_d = REDUCE;
            end
            REDUCE: begin
                cnt_d = cnt_inc;
                ra_d  = ra_nx;
                rb_d  = rb_nx;
                // The equality cycle itself is included in the reported count.
                if (eq) begin
                    state_d = DONE;
                    gcd_d   = res;
                    zero_d  = 1'b0;
                    cyc_d   = cnt_inc;
                end
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ra_q    <= '0;
            rb_q    <= '0;
            k_q     <= '0;
            cnt_q   <= '0;
            gcd_q   <= '0;
            zero_q  <= 1'b0;
            cyc_q   <= '0;
        end else begin
            state_q <= state_d;
            ra_q    <= ra_d;
            rb_q    <= rb_d;
            k_q     <= k_d;
            cnt_q   <= cnt_d;
            gcd_q   <= gcd_d;
            zero_q  <= zero_d;
            cyc_q   <= cyc_d;
        end
    end

endmodule
